// File: rtl/coord_packet_receiver_pkg.sv
// Shared definitions for the coordinate packet receiver and the servo controller.
package coord_packet_receiver_pkg;

    // Frame layout: sync byte, six payload bytes, checksum byte.
    localparam logic [7:0] SYNC_BYTE   = 8'hA5;
    localparam int         FRAME_LEN   = 8;
    localparam int         PAYLOAD_LEN = FRAME_LEN - 2;
    localparam int         FIELD_WIDTH = 16;

    // Legal coordinate ranges of the downstream controller.
    localparam int DEF_X_LIMIT = 2000;
    localparam int DEF_Y_MIN   = 1;
    localparam int DEF_Y_MAX   = 4000;
    localparam int DEF_Z_MAX   = 4000;

    typedef enum logic [1:0] {
        HUNT,
        PAYLOAD,
        CHECK,
        COMMIT
    } rx_state_e;

endpackage

// File: rtl/coord_packet_receiver_saturate.sv
// Combinational clamp of the three raw little-endian fields to the controller limits.
module coord_saturate
    import coord_packet_receiver_pkg::*;
#(
    parameter int COORD_WIDTH = 16,
    parameter int X_LIMIT     = DEF_X_LIMIT,
    parameter int Y_MIN       = DEF_Y_MIN,
    parameter int Y_MAX       = DEF_Y_MAX,
    parameter int Z_MAX       = DEF_Z_MAX
) (
    input  logic        [FIELD_WIDTH-1:0] raw_x,
    input  logic        [FIELD_WIDTH-1:0] raw_y,
    input  logic        [FIELD_WIDTH-1:0] raw_z,
    output logic signed [COORD_WIDTH-1:0] sat_x,
    output logic        [COORD_WIDTH-1:0] sat_y,
    output logic        [COORD_WIDTH-1:0] sat_z
);

    int x_val;
    int y_val;
    int z_val;

    // Sign-extend each field and clamp it; negative y falls onto Y_MIN.
    always_comb begin
        x_val = int'($signed(raw_x));
        y_val = int'($signed(raw_y));
        z_val = int'($signed(raw_z));

        if (x_val > X_LIMIT) begin
            x_val = X_LIMIT;
        end else if (x_val < -X_LIMIT) begin
            x_val = -X_LIMIT;
        end

        if (y_val > Y_MAX) begin
            y_val = Y_MAX;
        end else if (y_val < Y_MIN) begin
            y_val = Y_MIN;
        end

        if (z_val > Z_MAX) begin
            z_val = Z_MAX;
        end else if (z_val < 0) begin
            z_val = 0;
        end

        sat_x = COORD_WIDTH'(x_val);
        sat_y = COORD_WIDTH'(y_val);
        sat_z = COORD_WIDTH'(z_val);
    end

endmodule

// File: rtl/coord_packet_receiver.sv
// Parses 8-byte coordinate frames, checks the XOR checksum, saturates the
// fields and presents stable coordinates with a delayed settle strobe.
module coord_packet_receiver
    import coord_packet_receiver_pkg::*;
#(
    parameter int COORD_WIDTH    = 16,
    parameter int X_LIMIT        = DEF_X_LIMIT,
    parameter int Y_MIN          = DEF_Y_MIN,
    parameter int Y_MAX          = DEF_Y_MAX,
    parameter int Z_MAX          = DEF_Z_MAX,
    parameter int SETTLE_CYCLES  = 3,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic        [7:0]             in_byte,
    input  logic                          in_valid,
    output logic signed [COORD_WIDTH-1:0] x_coord,
    output logic        [COORD_WIDTH-1:0] y_coord,
    output logic        [COORD_WIDTH-1:0] z_coord,
    output logic                          coord_valid,
    output logic                          frame_err,
    output logic        [15:0]            err_count
);

    localparam int IDLE_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [IDLE_W-1:0]   IDLE_LAST   = IDLE_W'(TIMEOUT_CYCLES - 1);
    localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES);

    rx_state_e                        state_q, state_d;
    logic [2:0]                       idx_q, idx_d;
    logic [7:0]                       chk_q, chk_d;
    logic [PAYLOAD_LEN-1:0][7:0]      payload_q, payload_d;
    logic [IDLE_W-1:0]                idle_q, idle_d;
    logic [SETTLE_W-1:0]              settle_q, settle_d;
    logic signed [COORD_WIDTH-1:0]    x_q, x_d;
    logic [COORD_WIDTH-1:0]           y_q, y_d;
    logic [COORD_WIDTH-1:0]           z_q, z_d;
    logic                             coord_valid_q, coord_valid_d;
    logic                             frame_err_q, frame_err_d;
    logic [15:0]                      err_count_q, err_count_d;
    logic                             frame_bad;

    logic signed [COORD_WIDTH-1:0]    sat_x;
    logic [COORD_WIDTH-1:0]           sat_y;
    logic [COORD_WIDTH-1:0]           sat_z;

    coord_saturate #(
        .COORD_WIDTH (COORD_WIDTH),
        .X_LIMIT     (X_LIMIT),
        .Y_MIN       (Y_MIN),
        .Y_MAX       (Y_MAX),
        .Z_MAX       (Z_MAX)
    ) u_saturate (
        .raw_x (FIELD_WIDTH'({payload_q[1], payload_q[0]})),
        .raw_y (FIELD_WIDTH'({payload_q[3], payload_q[2]})),
        .raw_z (FIELD_WIDTH'({payload_q[5], payload_q[4]})),
        .sat_x (sat_x),
        .sat_y (sat_y),
        .sat_z (sat_z)
    );

    // Next-state logic: frame parser, idle timeout, settle countdown and error counter.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        chk_d         = chk_q;
        payload_d     = payload_q;
        idle_d        = idle_q;
        settle_d      = settle_q;
        x_d           = x_q;
        y_d           = y_q;
        z_d           = z_q;
        coord_valid_d = 1'b0;
        frame_err_d   = 1'b0;
        err_count_d   = err_count_q;
        frame_bad     = 1'b0;

        if (settle_q != '0) begin
            settle_d      = settle_q - 1'b1;
            coord_valid_d = (settle_q == SETTLE_W'(1));
        end

        case (state_q)
            HUNT: begin
                idle_d = '0;
                if (in_valid && in_byte == SYNC_BYTE) begin
                    state_d = PAYLOAD;
                    idx_d   = '0;
                    chk_d   = '0;
                end
            end
            PAYLOAD: begin
                if (in_valid) begin
                    idle_d            = '0;
                    payload_d[idx_q]  = in_byte;
                    chk_d             = chk_q ^ in_byte;
                    if (idx_q == 3'(PAYLOAD_LEN - 1)) begin
                        state_d = CHECK;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else if (idle_q == IDLE_LAST) begin
                    idle_d    = '0;
                    frame_bad = 1'b1;
                    state_d   = HUNT;
                end else begin
                    idle_d = idle_q + 1'b1;
                end
            end
            CHECK: begin
                if (in_valid) begin
                    idle_d = '0;
                    if (in_byte == chk_q) begin
                        state_d = COMMIT;
                    end else begin
                        frame_bad = 1'b1;
                        state_d   = HUNT;
                    end
                end else if (idle_q == IDLE_LAST) begin
                    idle_d    = '0;
                    frame_bad = 1'b1;
                    state_d   = HUNT;
                end else begin
                    idle_d = idle_q + 1'b1;
                end
            end
            COMMIT: begin
                x_d           = sat_x;
                y_d           = sat_y;
                z_d           = sat_z;
                settle_d      = SETTLE_LOAD;
                coord_valid_d = 1'b0;
                state_d       = HUNT;
            end
            default: begin
                state_d = HUNT;
            end
        endcase

        if (frame_bad) begin
            frame_err_d = 1'b1;
            if (err_count_q != 16'hFFFF) begin
                err_count_d = err_count_q + 16'd1;
            end
        end
    end

    // State and output registers, cleared immediately when reset is asserted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= HUNT;
            idx_q         <= '0;
            chk_q         <= '0;
            payload_q     <= '0;
            idle_q        <= '0;
            settle_q      <= '0;
            x_q           <= '0;
            y_q           <= '0;
            z_q           <= '0;
            coord_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            err_count_q   <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            chk_q         <= chk_d;
            payload_q     <= payload_d;
            idle_q        <= idle_d;
            settle_q      <= settle_d;
            x_q           <= x_d;
            y_q           <= y_d;
            z_q           <= z_d;
            coord_valid_q <= coord_valid_d;
            frame_err_q   <= frame_err_d;
            err_count_q   <= err_count_d;
        end
    end

    assign x_coord     = x_q;
    assign y_coord     = y_q;
    assign z_coord     = z_q;
    assign coord_valid = coord_valid_q;
    assign frame_err   = frame_err_q;
    assign err_count   = err_count_q;

endmodule

// File: tb/tb_coord_packet_receiver.sv
// Directed bench for coord_packet_receiver: one task per scenario with inline checks.
module tb_coord_packet_receiver;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [7:0] in_byte = 8'h00;
    logic in_valid = 1'b0;

    logic signed [15:0] x_coord;
    logic [15:0] y_coord, z_coord, err_count;
    logic coord_valid, frame_err;

    logic signed [15:0] long_x;
    logic [15:0] long_y, long_z, long_err_count;
    logic long_coord_valid, long_frame_err;

    int tests_run = 0;
    int tests_failed = 0;

    logic mon_en = 1'b0;
    int long_pulses = 0;
    logic [15:0] cap_x = '0, cap_y = '0, cap_z = '0;

    localparam logic [63:0] FRAME_A   = 64'hA5_9C_FF_E8_03_F4_01_7D;
    localparam logic [63:0] FRAME_SAT = 64'hA5_B8_0B_00_00_88_13_28;
    localparam logic [63:0] FRAME_BAD = 64'hA5_9C_FF_E8_03_F4_01_7C;
    localparam logic [63:0] FRAME_NEG = 64'hA5_64_00_FF_FF_F6_FF_6D;
    localparam logic [63:0] FRAME_LO  = 64'hA5_30_F8_A0_0F_00_00_67;
    localparam logic [63:0] FRAME_CLX = 64'hA5_48_F4_01_00_64_00_D9;

    always #5 clk = ~clk;

    coord_packet_receiver #(.TIMEOUT_CYCLES(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_byte     (in_byte),
        .in_valid    (in_valid),
        .x_coord     (x_coord),
        .y_coord     (y_coord),
        .z_coord     (z_coord),
        .coord_valid (coord_valid),
        .frame_err   (frame_err),
        .err_count   (err_count)
    );

    // Second instance with a long settle window so a commit can land mid-settle.
    coord_packet_receiver #(.SETTLE_CYCLES(10), .TIMEOUT_CYCLES(16)) dut_long (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_byte     (in_byte),
        .in_valid    (in_valid),
        .x_coord     (long_x),
        .y_coord     (long_y),
        .z_coord     (long_z),
        .coord_valid (long_coord_valid),
        .frame_err   (long_frame_err),
        .err_count   (long_err_count)
    );

    // Count settle strobes of the long instance and capture what they carry.
    always @(negedge clk) begin
        if (mon_en && long_coord_valid) begin
            long_pulses = long_pulses + 1;
            cap_x = long_x;
            cap_y = long_y;
            cap_z = long_z;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        in_byte  = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [63:0] f);
        for (int i = 7; i >= 0; i--) begin
            send_byte(f[i*8 +: 8]);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests_run++; if (x_coord !== 16'h0000) begin tests_failed++; $display("[TB] FAIL reset_x: got %h expected 0000", x_coord); end
        tests_run++; if (y_coord !== 16'h0000) begin tests_failed++; $display("[TB] FAIL reset_y: got %h expected 0000", y_coord); end
        tests_run++; if (z_coord !== 16'h0000) begin tests_failed++; $display("[TB] FAIL reset_z: got %h expected 0000", z_coord); end
        tests_run++; if (coord_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_valid: got %b expected 0", coord_valid); end
        tests_run++; if (frame_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_err: got %b expected 0", frame_err); end
        tests_run++; if (err_count !== 16'h0000) begin tests_failed++; $display("[TB] FAIL reset_count: got %h expected 0000", err_count); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tests_run++; if (coord_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL post_reset_valid: got %b expected 0", coord_valid); end
    endtask

    task automatic test_valid_frame();
        send_frame(FRAME_A);
        tests_run++; if (frame_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL valid_no_err: got %b expected 0", frame_err); end
        @(posedge clk); #1;
        tests_run++; if (x_coord !== 16'hFF9C) begin tests_failed++; $display("[TB] FAIL valid_x: got %h expected ff9c", x_coord); end
        tests_run++; if (y_coord !== 16'h03E8) begin tests_failed++; $display("[TB] FAIL valid_y: got %h expected 03e8", y_coord); end
        tests_run++; if (z_coord !== 16'h01F4) begin tests_failed++; $display("[TB] FAIL valid_z: got %h expected 01f4", z_coord); end
        tests_run++; if (coord_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL valid_early: got %b expected 0", coord_valid); end
        for (int k = 2; k <= 6; k++) begin
            @(posedge clk); #1;
            tests_run++; if (coord_valid !== (k == 4)) begin tests_failed++; $display("[TB] FAIL valid_strobe cycle %0d: got %b expected %b", k, coord_valid, (k == 4)); end
            tests_run++; if (frame_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL valid_err cycle %0d: got %b expected 0", k, frame_err); end
        end
    endtask

    task automatic test_saturation();
        send_frame(FRAME_SAT);
        @(posedge clk); #1;
        tests_run++; if (x_coord !== 16'h07D0) begin tests_failed++; $display("[TB] FAIL sat_x: got %h expected 07d0", x_coord); end
        tests_run++; if (y_coord !== 16'h0001) begin tests_failed++; $display("[TB] FAIL sat_y: got %h expected 0001", y_coord); end
        tests_run++; if (z_coord !== 16'h0FA0) begin tests_failed++; $display("[TB] FAIL sat_z: got %h expected 0fa0", z_coord); end
        for (int k = 2; k <= 6; k++) begin
            @(posedge clk); #1;
            tests_run++; if (coord_valid !== (k == 4)) begin tests_failed++; $display("[TB] FAIL sat_strobe cycle %0d: got %b expected %b", k, coord_valid, (k == 4)); end
        end
    endtask

    task automatic test_bad_checksum();
        send_frame(FRAME_BAD);
        tests_run++; if (frame_err !== 1'b1) begin tests_failed++; $display("[TB] FAIL bad_err_pulse: got %b expected 1", frame_err); end
        tests_run++; if (err_count !== 16'd1) begin tests_failed++; $display("[TB] FAIL bad_count: got %0d expected 1", err_count); end
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            tests_run++; if (frame_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL bad_err_width cycle %0d: got %b expected 0", k, frame_err); end
            tests_run++; if (coord_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL bad_no_valid cycle %0d: got %b expected 0", k, coord_valid); end
        end
        tests_run++; if (x_coord !== 16'h07D0) begin tests_failed++; $display("[TB] FAIL bad_hold_x: got %h expected 07d0", x_coord); end
        tests_run++; if (y_coord !== 16'h0001) begin tests_failed++; $display("[TB] FAIL bad_hold_y: got %h expected 0001", y_coord); end
        tests_run++; if (z_coord !== 16'h0FA0) begin tests_failed++; $display("[TB] FAIL bad_hold_z: got %h expected 0fa0", z_coord); end
    endtask

    task automatic test_junk();
        send_byte(8'h00);
        send_byte(8'h37);
        send_byte(8'h11);
        send_frame(FRAME_NEG);
        @(posedge clk); #1;
        tests_run++; if (x_coord !== 16'h0064) begin tests_failed++; $display("[TB] FAIL junk_x: got %h expected 0064", x_coord); end
        tests_run++; if (y_coord !== 16'h0001) begin tests_failed++; $display("[TB] FAIL junk_y_neg: got %h expected 0001", y_coord); end
        tests_run++; if (z_coord !== 16'h0000) begin tests_failed++; $display("[TB] FAIL junk_z_neg: got %h expected 0000", z_coord); end
        tests_run++; if (err_count !== 16'd1) begin tests_failed++; $display("[TB] FAIL junk_count: got %0d expected 1", err_count); end
        for (int k = 2; k <= 6; k++) begin
            @(posedge clk); #1;
            tests_run++; if (coord_valid !== (k == 4)) begin tests_failed++; $display("[TB] FAIL junk_strobe cycle %0d: got %b expected %b", k, coord_valid, (k == 4)); end
        end
    endtask

    task automatic test_timeout();
        send_byte(8'hA5);
        send_byte(8'h30);
        send_byte(8'hF8);
        for (int i = 1; i <= 18; i++) begin
            @(posedge clk); #1;
            tests_run++; if (frame_err !== (i == 16)) begin tests_failed++; $display("[TB] FAIL timeout_err idle %0d: got %b expected %b", i, frame_err, (i == 16)); end
        end
        tests_run++; if (err_count !== 16'd2) begin tests_failed++; $display("[TB] FAIL timeout_count: got %0d expected 2", err_count); end
        send_frame(FRAME_LO);
        @(posedge clk); #1;
        tests_run++; if (x_coord !== 16'hF830) begin tests_failed++; $display("[TB] FAIL after_to_x: got %h expected f830", x_coord); end
        tests_run++; if (y_coord !== 16'h0FA0) begin tests_failed++; $display("[TB] FAIL after_to_y: got %h expected 0fa0", y_coord); end
        tests_run++; if (z_coord !== 16'h0000) begin tests_failed++; $display("[TB] FAIL after_to_z: got %h expected 0000", z_coord); end
        tests_run++; if (err_count !== 16'd2) begin tests_failed++; $display("[TB] FAIL after_to_count: got %0d expected 2", err_count); end
    endtask

    task automatic test_back_to_back();
        repeat (15) @(posedge clk);
        #1;
        long_pulses = 0;
        mon_en = 1'b1;
        send_frame(FRAME_A);
        @(posedge clk);
        send_frame(FRAME_CLX);
        repeat (25) @(posedge clk);
        #1;
        mon_en = 1'b0;
        tests_run++; if (long_pulses !== 1) begin tests_failed++; $display("[TB] FAIL b2b_pulses: got %0d expected 1", long_pulses); end
        tests_run++; if (cap_x !== 16'hF830) begin tests_failed++; $display("[TB] FAIL b2b_x: got %h expected f830", cap_x); end
        tests_run++; if (cap_y !== 16'h0001) begin tests_failed++; $display("[TB] FAIL b2b_y: got %h expected 0001", cap_y); end
        tests_run++; if (cap_z !== 16'h0064) begin tests_failed++; $display("[TB] FAIL b2b_z: got %h expected 0064", cap_z); end
        tests_run++; if (x_coord !== 16'hF830) begin tests_failed++; $display("[TB] FAIL b2b_main_x: got %h expected f830", x_coord); end
    endtask

    task automatic test_reset_mid_frame();
        send_byte(8'hA5);
        send_byte(8'h9C);
        send_byte(8'hFF);
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++; if (x_coord !== 16'h0000) begin tests_failed++; $display("[TB] FAIL async_x: got %h expected 0000", x_coord); end
        tests_run++; if (y_coord !== 16'h0000) begin tests_failed++; $display("[TB] FAIL async_y: got %h expected 0000", y_coord); end
        tests_run++; if (z_coord !== 16'h0000) begin tests_failed++; $display("[TB] FAIL async_z: got %h expected 0000", z_coord); end
        tests_run++; if (err_count !== 16'h0000) begin tests_failed++; $display("[TB] FAIL async_count: got %h expected 0000", err_count); end
        @(negedge clk);
        rst_n = 1'b1;
        send_frame(FRAME_A);
        @(posedge clk); #1;
        tests_run++; if (x_coord !== 16'hFF9C) begin tests_failed++; $display("[TB] FAIL rst_frame_x: got %h expected ff9c", x_coord); end
        tests_run++; if (y_coord !== 16'h03E8) begin tests_failed++; $display("[TB] FAIL rst_frame_y: got %h expected 03e8", y_coord); end
        tests_run++; if (z_coord !== 16'h01F4) begin tests_failed++; $display("[TB] FAIL rst_frame_z: got %h expected 01f4", z_coord); end
        for (int k = 2; k <= 6; k++) begin
            @(posedge clk); #1;
            tests_run++; if (coord_valid !== (k == 4)) begin tests_failed++; $display("[TB] FAIL rst_strobe cycle %0d: got %b expected %b", k, coord_valid, (k == 4)); end
        end
    endtask

    // Run every scenario in order, then report.
    initial begin
        test_reset();
        test_valid_frame();
        test_saturation();
        test_bad_checksum();
        test_junk();
        test_timeout();
        test_back_to_back();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
